// File: rtl/data_pkg.sv
// Shared types and the round-robin pick helper for the data register write arbiter.
package data_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned BE_W     = 2;
  localparam int unsigned NREQ_MAX = 8;
  localparam int unsigned PTR_W    = 3;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic             found;
    logic [PTR_W-1:0] idx;
  } rr_result_t;

  // Rotate valid so ptr lands at bit 0, take the lowest set bit, then unrotate back to an index.
  function automatic rr_result_t rr_pick(input logic [NREQ_MAX-1:0] valid,
                                         input logic [PTR_W-1:0]    ptr,
                                         input int                  n);
    rr_result_t            r;
    logic [NREQ_MAX-1:0]   rot;
    logic [PTR_W-1:0]      j;
    int                    off;
    r   = '0;
    rot = '0;
    j   = '0;
    off = 0;
    for (int k = 0; k < int'(NREQ_MAX); k++) begin
      if (k < n) begin
        j      = PTR_W'((int'(ptr) + k) % n);
        rot[k] = valid[j];
      end
    end
    for (int k = int'(NREQ_MAX) - 1; k >= 0; k--) begin
      if (rot[k]) begin
        r.found = 1'b1;
        off     = k;
      end
    end
    r.idx = PTR_W'((int'(ptr) + off) % n);
    return r;
  endfunction

endpackage

// File: rtl/data_write_arbiter_if.sv
// Requester handshake bus plus the register write port of the arbiter.
interface data_write_arbiter_if
  import data_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ*BE_W-1:0]   req_byte_en;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      arb_hold;
  logic                      wr_en;
  logic [DATA_W-1:0]         wr_data;
  logic [BE_W-1:0]           wr_byte_en;
  logic [ID_W-1:0]           gnt_id;
  logic                      locked;

  modport master (
    output req_valid, req_data, req_byte_en, req_lock, arb_hold,
    input  req_ready, wr_en, wr_data, wr_byte_en, gnt_id, locked
  );

  modport slave (
    input  req_valid, req_data, req_byte_en, req_lock, arb_hold,
    output req_ready, wr_en, wr_data, wr_byte_en, gnt_id, locked
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin winner search starting at ptr.
module rr_picker
  import data_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    ptr,
  output logic               found_c,
  output logic [ID_W-1:0]    idx_c
);

  rr_result_t res;

  // Widen to the helper's fixed size; unused upper lanes are masked by n.
  always_comb res = rr_pick(NREQ_MAX'(valid), PTR_W'(ptr), int'(NUM_REQ));

  assign found_c = res.found;
  assign idx_c   = ID_W'(res.idx);

endmodule

// File: rtl/data_write_arbiter.sv
// Round-robin arbiter with locked bursts in front of the shared 16-bit data register.
module data_write_arbiter
  import data_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned MAX_LOCK = 4,
  parameter int unsigned ID_W     = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  data_write_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = 4;

  arb_state_t          state;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     owner;
  logic [CNT_W-1:0]    beat_cnt;
  logic [CNT_W-1:0]    beat_cnt_nxt;
  logic                wr_en_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic [BE_W-1:0]     wr_be_q;
  logic [ID_W-1:0]     gnt_id_q;

  logic                pick_found;
  logic [ID_W-1:0]     pick_idx;
  logic [NUM_REQ-1:0]  ready_c;
  logic [ID_W-1:0]     win;
  logic                xfer;
  logic [DATA_W-1:0]   win_data;
  logic [BE_W-1:0]     win_be;
  logic                win_lock;

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] x);
    return (int'(x) == int'(NUM_REQ) - 1) ? '0 : x + ID_W'(1);
  endfunction

  rr_picker #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_picker (
    .valid   (bus.req_valid),
    .ptr     (rr_ptr),
    .found_c (pick_found),
    .idx_c   (pick_idx)
  );

  // Grant selection and winner lane mux; ready is suppressed during reset and hold.
  always_comb begin
    ready_c  = '0;
    win      = rr_ptr;
    xfer     = 1'b0;
    win_data = '0;
    win_be   = '0;
    win_lock = 1'b0;
    if (rst_n && !bus.arb_hold) begin
      if (state == IDLE) begin
        if (pick_found) begin
          win  = pick_idx;
          xfer = 1'b1;
        end
      end else if (bus.req_valid[owner]) begin
        win  = owner;
        xfer = 1'b1;
      end
    end
    if (xfer) ready_c[win] = 1'b1;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (ID_W'(i) == win) begin
        win_data = bus.req_data[i*DATA_W +: DATA_W];
        win_be   = bus.req_byte_en[i*BE_W +: BE_W];
        win_lock = bus.req_lock[i];
      end
    end
  end

  assign beat_cnt_nxt = beat_cnt + CNT_W'(1);

  // Lock FSM, rotation pointer and registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      beat_cnt  <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      wr_be_q   <= '0;
      gnt_id_q  <= '0;
    end else begin
      wr_en_q <= 1'b0;
      if (xfer) begin
        wr_en_q   <= |win_be;
        wr_data_q <= win_data;
        wr_be_q   <= win_be;
        gnt_id_q  <= win;
        if (state == IDLE) begin
          if (win_lock && MAX_LOCK > 1) begin
            state    <= LOCKED;
            owner    <= win;
            beat_cnt <= CNT_W'(1);
          end else begin
            rr_ptr <= next_id(win);
          end
        end else begin
          if (!win_lock || beat_cnt_nxt == CNT_W'(MAX_LOCK)) begin
            state    <= IDLE;
            rr_ptr   <= next_id(owner);
            beat_cnt <= '0;
          end else begin
            beat_cnt <= beat_cnt_nxt;
          end
        end
      end
    end
  end

  assign bus.req_ready  = ready_c;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.wr_byte_en = wr_be_q;
  assign bus.gnt_id     = gnt_id_q;
  assign bus.locked     = (state == LOCKED);

endmodule

// File: tb/tb_data_write_arbiter.sv
// Scoreboard bench for data_write_arbiter: per-requester beat queues, expected write beats queue.
module tb_data_write_arbiter;
  import data_pkg::*;

  localparam int unsigned NR = 4;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  be;
    logic        lock;
  } beat_t;

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] data;
    logic [1:0]  be;
    logic        en;
    logic        lk;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  data_write_arbiter_if #(.NUM_REQ(NR)) bus ();

  data_write_arbiter #(.NUM_REQ(NR), .MAX_LOCK(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  beat_t         rq [NR][$];
  exp_t          sb [$];
  logic [NR-1:0] hs_last;
  int            checks = 0;
  int            passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic put(input int r, input logic [15:0] d, input logic [1:0] be, input logic lk);
    beat_t b;
    b.data = d; b.be = be; b.lock = lk;
    rq[r].push_back(b);
  endtask

  task automatic expect_beat(input int id, input logic [15:0] d, input logic [1:0] be,
                             input logic en, input logic lk);
    exp_t e;
    e.id = 2'(id); e.data = d; e.be = be; e.en = en; e.lk = lk;
    sb.push_back(e);
  endtask

  // Wait (at posedge+3) until every expected beat has been seen; returns cycles taken.
  task automatic drain(input int budget, output int n);
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk); #3;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout: %0d beats still outstanding after %0d cycles", sb.size(), n);
      sb.delete();
      for (int i = 0; i < int'(NR); i++) rq[i].delete();
    end
  endtask

  // Requester driver: retire accepted beats, present queue heads, record coming handshakes.
  initial begin
    bus.req_valid   = '0;
    bus.req_data    = '0;
    bus.req_byte_en = '0;
    bus.req_lock    = '0;
    hs_last         = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < int'(NR); i++) begin
        if (hs_last[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        if (rq[i].size() > 0) begin
          bus.req_valid[i]          = 1'b1;
          bus.req_data[i*16 +: 16]  = rq[i][0].data;
          bus.req_byte_en[i*2 +: 2] = rq[i][0].be;
          bus.req_lock[i]           = rq[i][0].lock;
        end else begin
          bus.req_valid[i] = 1'b0;
          bus.req_lock[i]  = 1'b0;
        end
      end
      #1 hs_last = bus.req_valid & bus.req_ready;
    end
  end

  // Monitor: after each edge, compare the write port with the next expected beat.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #2;
      if (hs_last != '0) begin
        chk("ready_onehot", 32'($onehot(hs_last)), 32'd1);
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_beat: got id %0d data 0x%0h, expected no beat",
                   bus.gnt_id, bus.wr_data);
        end else begin
          e = sb.pop_front();
          chk("gnt_id",     32'(bus.gnt_id),     32'(e.id));
          chk("wr_data",    32'(bus.wr_data),    32'(e.data));
          chk("wr_byte_en", 32'(bus.wr_byte_en), 32'(e.be));
          chk("wr_en",      32'(bus.wr_en),      32'(e.en));
          chk("locked",     32'(bus.locked),     32'(e.lk));
        end
      end else begin
        chk("idle_wr_en", 32'(bus.wr_en), 32'd0);
      end
    end
  end

  // Directed stimulus.
  initial begin
    int n;
    bus.arb_hold = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst0_wr_en",  32'(bus.wr_en),      32'd0);
    chk("rst0_data",   32'(bus.wr_data),    32'd0);
    chk("rst0_be",     32'(bus.wr_byte_en), 32'd0);
    chk("rst0_gnt",    32'(bus.gnt_id),     32'd0);
    chk("rst0_locked", 32'(bus.locked),     32'd0);

    // Rotation: all four valid, unlocked.
    for (int k = 0; k < 2; k++) begin
      put(0, 16'hA0A0, 2'b11, 1'b0);
      put(1, 16'hB1B1, 2'b11, 1'b0);
      put(2, 16'hC2C2, 2'b11, 1'b0);
      put(3, 16'hD3D3, 2'b11, 1'b0);
      expect_beat(0, 16'hA0A0, 2'b11, 1'b1, 1'b0);
      expect_beat(1, 16'hB1B1, 2'b11, 1'b1, 1'b0);
      expect_beat(2, 16'hC2C2, 2'b11, 1'b1, 1'b0);
      expect_beat(3, 16'hD3D3, 2'b11, 1'b1, 1'b0);
    end
    @(negedge clk); #2;
    chk("rst_ready_low", 32'(bus.req_ready), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    drain(40, n);
    chk("rotation_cycles", 32'(n), 32'd8);

    // Move the pointer to 2, then a 3-beat lock on requester 2 with 0 and 1 waiting.
    put(1, 16'h1111, 2'b11, 1'b0);
    expect_beat(1, 16'h1111, 2'b11, 1'b1, 1'b0);
    drain(20, n);
    put(0, 16'h0A01, 2'b11, 1'b0);
    put(0, 16'h0A02, 2'b11, 1'b0);
    put(1, 16'h1B01, 2'b11, 1'b0);
    put(2, 16'h2C01, 2'b11, 1'b1);
    put(2, 16'h2C02, 2'b11, 1'b1);
    put(2, 16'h2C03, 2'b11, 1'b0);
    expect_beat(2, 16'h2C01, 2'b11, 1'b1, 1'b1);
    expect_beat(2, 16'h2C02, 2'b11, 1'b1, 1'b1);
    expect_beat(2, 16'h2C03, 2'b11, 1'b1, 1'b0);
    expect_beat(0, 16'h0A01, 2'b11, 1'b1, 1'b0);
    expect_beat(1, 16'h1B01, 2'b11, 1'b1, 1'b0);
    expect_beat(0, 16'h0A02, 2'b11, 1'b1, 1'b0);
    drain(40, n);

    // Cap: requester 1 keeps lock for 6 beats; released after the 4th, 2 wins next.
    for (int k = 1; k <= 6; k++) put(1, 16'(16'h1000 + k), 2'b11, 1'b1);
    put(2, 16'h2002, 2'b11, 1'b0);
    expect_beat(1, 16'h1001, 2'b11, 1'b1, 1'b1);
    expect_beat(1, 16'h1002, 2'b11, 1'b1, 1'b1);
    expect_beat(1, 16'h1003, 2'b11, 1'b1, 1'b1);
    expect_beat(1, 16'h1004, 2'b11, 1'b1, 1'b0);
    expect_beat(2, 16'h2002, 2'b11, 1'b1, 1'b0);
    expect_beat(1, 16'h1005, 2'b11, 1'b1, 1'b1);
    expect_beat(1, 16'h1006, 2'b11, 1'b1, 1'b1);
    drain(40, n);

    // Hold for 3 cycles while requester 1 owns the lock with two beats counted.
    bus.arb_hold = 1'b1;
    put(0, 16'h0D0D, 2'b11, 1'b0);
    put(1, 16'h1007, 2'b11, 1'b1);
    put(1, 16'h1008, 2'b11, 1'b1);
    put(1, 16'h1009, 2'b11, 1'b0);
    expect_beat(1, 16'h1007, 2'b11, 1'b1, 1'b1);
    expect_beat(1, 16'h1008, 2'b11, 1'b1, 1'b0);
    expect_beat(0, 16'h0D0D, 2'b11, 1'b1, 1'b0);
    expect_beat(1, 16'h1009, 2'b11, 1'b1, 1'b0);
    repeat (3) begin
      @(negedge clk); #2;
      chk("hold_ready",  32'(bus.req_ready), 32'd0);
      chk("hold_locked", 32'(bus.locked),    32'd1);
    end
    @(posedge clk); #3 bus.arb_hold = 1'b0;
    drain(40, n);

    // Byte enables, including an accepted 00 beat that still rotates.
    put(2, 16'h12AB, 2'b01, 1'b0);
    put(3, 16'h34CD, 2'b10, 1'b0);
    put(0, 16'h5555, 2'b00, 1'b0);
    put(0, 16'h6666, 2'b11, 1'b0);
    put(1, 16'h7777, 2'b11, 1'b0);
    expect_beat(2, 16'h12AB, 2'b01, 1'b1, 1'b0);
    expect_beat(3, 16'h34CD, 2'b10, 1'b1, 1'b0);
    expect_beat(0, 16'h5555, 2'b00, 1'b0, 1'b0);
    expect_beat(1, 16'h7777, 2'b11, 1'b1, 1'b0);
    expect_beat(0, 16'h6666, 2'b11, 1'b1, 1'b0);
    drain(40, n);

    // Reset in the middle of a locked burst from requester 1.
    for (int k = 1; k <= 4; k++) put(1, 16'(16'h5100 + k), 2'b11, 1'b1);
    expect_beat(1, 16'h5101, 2'b11, 1'b1, 1'b1);
    expect_beat(1, 16'h5102, 2'b11, 1'b1, 1'b1);
    drain(20, n);
    rst_n = 1'b0;
    #1;
    chk("rst_wr_en",  32'(bus.wr_en),      32'd0);
    chk("rst_data",   32'(bus.wr_data),    32'd0);
    chk("rst_be",     32'(bus.wr_byte_en), 32'd0);
    chk("rst_gnt",    32'(bus.gnt_id),     32'd0);
    chk("rst_locked", 32'(bus.locked),     32'd0);
    chk("rst_ready",  32'(bus.req_ready),  32'd0);
    for (int i = 0; i < int'(NR); i++) rq[i].delete();
    put(2, 16'h2222, 2'b11, 1'b0);
    put(3, 16'h3333, 2'b11, 1'b0);
    expect_beat(2, 16'h2222, 2'b11, 1'b1, 1'b0);
    expect_beat(3, 16'h3333, 2'b11, 1'b1, 1'b0);
    @(negedge clk); #2;
    chk("rst_ready_held", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    drain(20, n);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
